sweep_ctrl_13: RTL and testbench
================================

# sweep_ctrl_13

Sequencer for the 13-bit falling-edge event counter: on a start request it clears the counter, then issues a programmed number of single-cycle count enables at a programmable rate, and reports completion. It sits between the board-level control logic (buttons/switches or a host FSM) and the counter's enable/reset pins, and can optionally re-run sweeps back-to-back.

## Interface
- BIT_SZ, 13, width of the sweep length and of the counter being driven
- DIV_W, 16, width of the rate divider
- clk  in  1  controller clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  terminate a sweep in progress
- loop  in  1  continuous mode; sampled with start
- len  in  BIT_SZ  number of count enables per sweep; sampled with start
- div  in  DIV_W  enable period minus one, in clk cycles; sampled with start
- cnt_en  out  1  drives the counter's enable
- cnt_rst  out  1  drives the counter's reset
- busy  out  1  high in CLEAR and RUN
- done  out  1  one-cycle pulse at the end of each sweep
- aborted  out  1  one-cycle pulse when a sweep is aborted

## Operation
- States: IDLE, CLEAR, RUN, DONE. All outputs decode registered state only; no combinational input-to-output path.
- Internal registers: len_l, div_l, loop_l (latched at start), prescaler (DIV_W bits), ticks (BIT_SZ bits).
- IDLE: all outputs 0. The counter holds its last value.
  - start=1, abort=0, len≠0: latch len/div/loop, go to CLEAR.
  - start=1, abort=0, len=0: go directly to DONE; no cnt_rst, no cnt_en.
  - abort=1 in IDLE: start is ignored and no pulse is generated.
- CLEAR: cnt_rst=1, busy=1 for exactly one cycle. Clear prescaler and ticks, then go to RUN.
- RUN: busy=1.
  - When prescaler==div_l: cnt_en=1 for this cycle, prescaler←0, ticks←ticks+1. If ticks+1==len_l, go to DONE.
  - Otherwise prescaler increments.
  - Comparison is done at full BIT_SZ width, so len=8191 never wraps ticks.
- DONE: done=1 for one cycle, busy=0.
  - loop_l=0: go to IDLE.
  - loop_l=1: go to CLEAR (busy returns the next cycle). Latched len/div are reused.
- abort=1 in CLEAR or RUN: next state IDLE, aborted=1 for that one cycle, done not pulsed, no further cnt_en or cnt_rst. abort in DONE is ignored; DONE completes normally. In loop mode, abort is the only exit.
- start while not in IDLE is ignored. len/div/loop changes mid-sweep have no effect.
- reset: state←IDLE; prescaler, ticks, len_l, div_l, loop_l←0. All outputs are 0 from the cycle after reset is sampled. This applies mid-sweep too.

## Timing
- Reset values: cnt_en=0, cnt_rst=0, busy=0, done=0, aborted=0.
- start sampled at rising edge k (len≠0): CLEAR during cycle k+1, RUN begins at cycle k+2.
- First cnt_en occurs in cycle k+2+div_l; subsequent enables every div_l+1 cycles.
- The last enable (the len_l-th) is in cycle k+1+len_l·(div_l+1). done is in the following cycle.
- Sweep duration start→done: len_l·(div_l+1)+2 cycles. With len=0, done occurs in cycle k+1.
- The counter samples on the falling edge of clk. cnt_rst and cnt_en are stable from the rising edge, which gives a half-cycle setup. After a completed sweep the counter reads len_l.
- Loop mode: consecutive done pulses are len_l·(div_l+1)+2 cycles apart.

## Test plan
- Reset: hold reset 2 cycles with start=1 -> all outputs 0, and no CLEAR afterwards until a new start in IDLE.
- Basic sweep: len=5, div=2, loop=0, start at edge k -> cnt_rst in cycle k+1; cnt_en in cycles k+4, k+7, k+10, k+13, k+16; done in k+17; busy high k+1..k+16; counter=5.
- Max length: len=8191, div=0 -> cnt_en high for 8191 consecutive cycles, done after 8193 cycles, counter=8191 with no wrap.
- Abort: len=10, div=1, abort after the 3rd cnt_en -> aborted pulse one cycle, no done, no further cnt_en, busy=0, counter=3. Abort and start together in IDLE -> nothing happens.
- Loop and ignored start: loop=1, len=2, div=0 -> done every 4 cycles with cnt_rst before each pass; start pulsed mid-RUN changes nothing; abort exits to IDLE.
- Edge cases: start with len=0 -> done next cycle, with no cnt_rst or cnt_en. reset asserted mid-RUN -> all outputs 0 the next cycle, and the state is IDLE.

Source files
------------

// File: rtl/sweep_ctrl_13.sv
// -----------------------------------------------------------------------------
// sweep_ctrl_13
//
// Sequencer for a 13-bit falling-edge event counter. On a start request it
// clears the counter for one cycle, then issues len single-cycle count enables
// spaced div+1 cycles apart, and finally pulses done. In loop mode it restarts
// the sweep after every done until aborted. Every output is decoded from
// registered state, so the counter (which samples on the falling clk edge)
// always sees stable enable/reset levels from the rising edge onward.
//
// Ports
//   clk      in   controller clock, rising-edge
//   reset    in   synchronous, active-high reset
//   start    in   sweep request, honoured only in IDLE
//   abort    in   terminate a sweep in CLEAR or RUN
//   loop     in   continuous mode, sampled with start
//   len      in   [BIT_SZ] enables per sweep, sampled with start
//   div      in   [DIV_W]  enable period minus one, sampled with start
//   cnt_en   out  counter enable
//   cnt_rst  out  counter reset
//   busy     out  high in CLEAR and RUN
//   done     out  one-cycle pulse at the end of each sweep
//   aborted  out  one-cycle pulse after a sweep is aborted
// -----------------------------------------------------------------------------
module sweep_ctrl_13 #(
    parameter int BIT_SZ = 13,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [BIT_SZ-1:0] len,
    input  logic [DIV_W-1:0]  div,
    output logic              cnt_en,
    output logic              cnt_rst,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    prescaler_q, prescaler_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_SZ-1:0]   ticks_q, ticks_d;
    logic [BIT_SZ-1:0]   len_q, len_d;
    logic                loop_q, loop_d;
    logic                aborted_q, aborted_d;

    // One extra bit so ticks+1 is compared at full width and never wraps,
    // even for len = 2**BIT_SZ - 1.
    logic [BIT_SZ:0]     ticks_inc;
    logic                period_hit;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        ticks_d     = ticks_q;
        len_d       = len_q;
        div_d       = div_q;
        loop_d      = loop_q;
        aborted_d   = 1'b0;
        cnt_en      = 1'b0;
        cnt_rst     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        period_hit  = (prescaler_q == div_q);
        ticks_inc   = {1'b0, ticks_q} + (BIT_SZ+1)'(1);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    len_d = len;
                    div_d = div;
                    if (len != '0) begin
                        loop_d  = loop;
                        state_d = S_CLEAR;
                    end else begin
                        // A zero-length sweep is a single done pulse and
                        // must never re-enter CLEAR with stale settings.
                        loop_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            S_CLEAR: begin
                cnt_rst     = 1'b1;
                busy        = 1'b1;
                prescaler_d = '0;
                ticks_d     = '0;
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                busy   = 1'b1;
                cnt_en = period_hit;
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (period_hit) begin
                    prescaler_d = '0;
                    ticks_d     = ticks_inc[BIT_SZ-1:0];
                    if (ticks_inc == {1'b0, len_q}) begin
                        state_d = S_DONE;
                    end
                end else begin
                    prescaler_d = prescaler_q + DIV_W'(1);
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = loop_q ? S_CLEAR : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The abort pulse is registered so it reflects state, not the live input.
    assign aborted = aborted_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prescaler_q <= '0;
            ticks_q     <= '0;
            len_q       <= '0;
            div_q       <= '0;
            loop_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            ticks_q     <= ticks_d;
            len_q       <= len_d;
            div_q       <= div_d;
            loop_q      <= loop_d;
            aborted_q   <= aborted_d;
        end
    end

endmodule

// File: tb/tb_sweep_ctrl_13.sv
// -----------------------------------------------------------------------------
// tb_sweep_ctrl_13
//
// Self-checking bench for sweep_ctrl_13. A timeline model predicts every
// output from the cycle index within the current sweep pass; a compare
// process checks all outputs on each falling edge. Directed sequences pin the
// model with literal cycle numbers, a board-counter emulation confirms the
// final counter values, and a randomized phase exercises everything else.
// -----------------------------------------------------------------------------
module tb_sweep_ctrl_13;

    localparam int BIT_SZ = 13;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              loop;
    logic [BIT_SZ-1:0] len;
    logic [DIV_W-1:0]  div;
    logic              cnt_en;
    logic              cnt_rst;
    logic              busy;
    logic              done;
    logic              aborted;

    int n_checks = 0;
    int n_fail   = 0;

    sweep_ctrl_13 #(.BIT_SZ(BIT_SZ), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .loop    (loop),
        .len     (len),
        .div     (div),
        .cnt_en  (cnt_en),
        .cnt_rst (cnt_rst),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Board counter: samples cnt_rst/cnt_en on the falling edge, like the real part.
    logic [BIT_SZ-1:0] board_cnt = '0;
    always @(negedge clk) begin
        if (cnt_rst === 1'b1)     board_cnt <= '0;
        else if (cnt_en === 1'b1) board_cnt <= board_cnt + 13'd1;
    end

    // ---------------- timeline model ----------------
    // A sweep pass is described by t = cycles since its origin edge:
    // t=1 clear, enables where (t-1) is a multiple of div+1, t=P done.
    bit m_valid = 1'b0;
    bit m_sweep = 1'b0;
    bit m_abp   = 1'b0;
    bit m_loop  = 1'b0;
    int m_t     = 0;
    int m_len   = 0;
    int m_div   = 0;

    function automatic int pass_len();
        if (m_len == 0) return 1;
        return m_len * (m_div + 1) + 2;
    endfunction

    function automatic logic [4:0] exp_vec();
        int   p;
        logic en, rst, bz, dn;
        if (!m_sweep) return {4'b0000, m_abp};
        p   = pass_len();
        rst = (m_len != 0) && (m_t == 1);
        bz  = (m_len != 0) && (m_t <= p - 1);
        en  = bz && (m_t >= 2) && (((m_t - 1) % (m_div + 1)) == 0);
        dn  = (m_t == p);
        return {en, rst, bz, dn, m_abp};
    endfunction

    task automatic model_step();
        bit busy_now;
        busy_now = exp_vec()[2];
        if (reset) begin
            m_sweep = 1'b0;
            m_abp   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_abp = 1'b0;
            if (!m_sweep) begin
                if (start && !abort) begin
                    m_len   = int'(len);
                    m_div   = int'(div);
                    m_loop  = loop && (len != '0);
                    m_sweep = 1'b1;
                    m_t     = 1;
                end
            end else if (busy_now && abort) begin
                m_sweep = 1'b0;
                m_abp   = 1'b1;
            end else if (m_t == pass_len()) begin
                if (m_loop) m_t = 1;
                else        m_sweep = 1'b0;
            end else begin
                m_t++;
            end
        end
    endtask

    // Compare process: outputs checked every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_valid)
            check("cycle_outputs", 32'({cnt_en, cnt_rst, busy, done, aborted}), 32'(exp_vec()));
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a start; returns in cycle 1 of the sweep (the CLEAR cycle).
    task automatic launch(input int l, input int d, input bit lp);
        len   = BIT_SZ'(l);
        div   = DIV_W'(d);
        loop  = lp;
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int en_n, first_en, last_en, done_at, seen, guard;

        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        loop  = 1'b0;
        len   = 13'd5;
        div   = 16'd0;

        // Reset held two cycles with start high.
        tick();
        check("reset_outs_c1", 32'({cnt_en, cnt_rst, busy, done, aborted}), 32'd0);
        tick();
        check("reset_outs_c2", 32'({cnt_en, cnt_rst, busy, done, aborted}), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_idle", 32'({cnt_rst, busy}), 32'd0);
        end

        // Basic sweep len=5 div=2; mid-sweep input changes must be ignored.
        launch(5, 2, 1'b0);
        len  = 13'h1abc;
        div  = 16'd7;
        loop = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            check($sformatf("basic_en_c%0d", i),   32'(cnt_en),  32'(i inside {4, 7, 10, 13, 16}));
            check($sformatf("basic_rst_c%0d", i),  32'(cnt_rst), 32'(i == 1));
            check($sformatf("basic_busy_c%0d", i), 32'(busy),    32'(i >= 1 && i <= 16));
            check($sformatf("basic_done_c%0d", i), 32'(done),    32'(i == 17));
            tick();
        end
        loop = 1'b0;
        check("basic_count", 32'(board_cnt), 32'd5);

        // Maximum length, back-to-back enables, no wrap.
        launch(8191, 0, 1'b0);
        en_n = 0; first_en = 0; last_en = 0; done_at = 0;
        for (int i = 1; i <= 8300 && done_at == 0; i++) begin
            if (cnt_en === 1'b1) begin
                en_n++;
                if (first_en == 0) first_en = i;
                last_en = i;
            end
            if (done === 1'b1) done_at = i;
            tick();
        end
        check("max_en_count", 32'(en_n),     32'd8191);
        check("max_first_en", 32'(first_en), 32'd2);
        check("max_last_en",  32'(last_en),  32'd8192);
        check("max_done_at",  32'(done_at),  32'd8193);
        check("max_count",    32'(board_cnt), 32'd8191);

        // Abort during the cycle of the third enable.
        launch(10, 1, 1'b0);
        seen = 0; guard = 0;
        while (seen < 3 && guard < 40) begin
            if (cnt_en === 1'b1) seen++;
            if (seen < 3) begin
                tick();
                guard++;
            end
        end
        check("abort_third_en_seen", 32'(seen), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", 32'({aborted, busy, done, cnt_en}), 32'b1000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_after", 32'({aborted, busy, done, cnt_en, cnt_rst}), 32'd0);
        end
        check("abort_count", 32'(board_cnt), 32'd3);

        // Start together with abort in IDLE does nothing.
        len   = 13'd4;
        div   = 16'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("idle_start_abort", 32'({busy, cnt_rst, done, aborted}), 32'd0);
        tick();
        check("idle_start_abort_2", 32'({busy, cnt_rst, done, aborted}), 32'd0);

        // Loop mode len=2 div=0: pass of 4 cycles; a mid-RUN start is ignored.
        launch(2, 0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            check($sformatf("loop_done_c%0d", i), 32'(done),    32'((i % 4) == 0));
            check($sformatf("loop_rst_c%0d", i),  32'(cnt_rst), 32'((i % 4) == 1));
            check($sformatf("loop_en_c%0d", i),   32'(cnt_en),  32'((i % 4) == 2 || (i % 4) == 3));
            if (i == 2) begin
                start = 1'b1;
                len   = 13'd7;
                div   = 16'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("loop_fourth_clear", 32'(cnt_rst), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort", 32'({aborted, busy, done}), 32'b100);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("loop_exited", 32'({busy, done, cnt_rst}), 32'd0);
        end

        // Zero length: done next cycle, nothing else.
        launch(0, 3, 1'b0);
        check("zero_len_cycle1", 32'({done, cnt_rst, cnt_en, busy}), 32'b1000);
        tick();
        check("zero_len_cycle2", 32'({done, busy}), 32'd0);

        // Reset mid-RUN; IDLE afterwards proven by an accepted start.
        launch(20, 1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("mid_run_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_run_reset", 32'({cnt_en, cnt_rst, busy, done, aborted}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after_reset_idle", 32'(busy), 32'd0);
        end
        launch(1, 0, 1'b0);
        check("restart_clear", 32'(cnt_rst), 32'd1);
        tick();
        check("restart_en", 32'(cnt_en), 32'd1);
        tick();
        check("restart_done", 32'(done), 32'd1);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 29) == 0);
            loop  = ($urandom_range(0, 3) == 0);
            len   = ($urandom_range(0, 9) == 0) ? '0 : BIT_SZ'($urandom_range(1, 6));
            div   = DIV_W'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
